fp_writeback_arbiter: RTL and testbench
=======================================

Name: fp_writeback_arbiter

Overview:
- Write-side front end of the FP register file (f0-f31).
- Merges results from N_SRC FP producers (e.g. FMA pipe, div/sqrt unit, FP load) onto the file's single write port. Producers use valid/ready handshakes and are served round-robin.
- Keeps a 32-entry pending-write scoreboard so issue logic can detect RAW/WAW hazards on rs1/rs2/rs3/rd.

Parameters:
- N_SRC, 3, number of result producers (1 to 8).
- DATA_W, 32, FP register width.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- src_valid  in  N_SRC  producer i has a result.
- src_ready  out  N_SRC  producer i's result accepted this cycle.
- src_rd  in  N_SRC*ADDR_W  destination register; slice i is bits [i*ADDR_W +: ADDR_W].
- src_data  in  N_SRC*DATA_W  result value; slice i is bits [i*DATA_W +: DATA_W].
- rd_addr  out  ADDR_W  to register file write address.
- wr_data  out  DATA_W  to register file write data.
- wr_en  out  1  to register file write enable.
- issue_valid  in  1  an FP instruction with an FP destination is issuing.
- issue_rd  in  ADDR_W  destination of the issuing instruction.
- chk_rs1, chk_rs2, chk_rs3, chk_rd  in  ADDR_W each  hazard query addresses.
- busy_rs1, busy_rs2, busy_rs3, busy_rd  out  1 each  scoreboard bit for the queried register.
- busy_vec  out  32  full scoreboard.
- err_sticky  out  1  protocol violation seen since reset.

Behaviour:
- Reset (rst=1 at an edge):
  - wr_en=0, rd_addr=0, wr_data=0.
  - busy_vec=0, err_sticky=0.
  - Round-robin pointer=0.
  - Reset overrides every same-cycle event. In-flight results are dropped; producers must also be reset.
- src_ready is combinational, but only while not in reset. Exactly one grant is made when any src_valid is high; with no valid source, src_ready=0.
- Arbitration:
  - Search starts at index ptr and wraps modulo N_SRC. The first valid source is granted.
  - After a grant to source g, ptr becomes (g+1) mod N_SRC. If nothing is granted, ptr holds.
  - A producer holding valid is granted within N_SRC cycles.
- Handshake: a transfer occurs when src_valid[i] && src_ready[i]. Producers hold rd and data stable until that transfer.
- Write port is registered, with 1-cycle latency:
  - A transfer in cycle t gives wr_en=1 and the registered rd_addr/wr_data in cycle t+1.
  - The register file captures the value at the end of cycle t+1.
  - With no transfer, wr_en=0 next cycle; rd_addr and wr_data hold their last values.
- Throughput is one write per cycle with back-to-back grants and no bubbles.
- Scoreboard set: issue_valid in cycle t sets busy_vec[issue_rd] at the end of t.
- Scoreboard clear: busy_vec[rd_addr] clears at the end of any cycle with wr_en=1, the same edge the register file writes. busy is therefore still 1 during the wr_en cycle.
- Same-edge set and clear of the same register: set wins, so busy stays 1 (a new producer owns the register).
- Same-edge set and clear of different registers: both take effect.
- Hazard outputs are combinational from current state: busy_rsN = busy_vec[chk_rsN], busy_rd = busy_vec[chk_rd]. Queries do not see a same-cycle issue.
- f0 is an ordinary register with no special case.
- err_sticky goes high (cleared only by rst) on either violation:
  - issue_valid while busy_vec[issue_rd]=1, unless that register is being cleared on the same edge (WAW issue);
  - wr_en=1 while busy_vec[rd_addr]=0 (unexpected writeback).
- Neither violation changes any other behaviour: an unexpected write is still performed.

Test Plan:
- Reset with all inputs toggling, rst=1 for 2 cycles -> wr_en=0, busy_vec=0, err_sticky=0, src_ready=0 throughout.
- Issue f5 at t0. At t2 source 1 presents rd=5, data=32'h3F800000 -> src_ready[1]=1 at t2. wr_en=1 with rd_addr=5, wr_data=3F800000 at t3. busy_vec[5] goes 0->1 after t0, 1->0 after t3, and busy_rd (chk_rd=5) reads 1 during t3.
- Issue f1, f2, f3. All 3 sources valid from t0 with rd=1,2,3, ptr=0 -> grants 0,1,2 in t0, t1, t2. Writes land t1-t3 with no bubbles. After the final write, busy_vec=0 and ptr=0.
- Sources 0 and 2 held valid continuously (each re-presents a new result for its own issued register after every handshake) -> grants alternate 0,2,0,2; neither is starved.
- Writeback of f7 with wr_en=1 in cycle t, and issue_valid with issue_rd=7 in the same cycle -> busy_vec[7]=1 after the edge, err_sticky stays 0.
- Source 0 delivers rd=9 with f9 never issued -> write still performed, err_sticky=1 one cycle after wr_en. Assert rst mid-stream with 2 sources valid -> next cycle wr_en=0, busy_vec=0, err_sticky=0.

Source files
------------

// File: rtl/fp_writeback_arbiter.sv
// fp_writeback_arbiter
//   Write-side front end of the FP register file (f0-f31). Merges results
//   from N_SRC producers onto the single write port using a round-robin
//   arbiter. It also keeps a 32-entry pending-write scoreboard, which issue
//   logic uses to detect RAW/WAW hazards.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   src_valid/src_ready          per-producer handshake (ready is combinational)
//   src_rd, src_data             flattened per-producer destination / value
//   rd_addr, wr_data, wr_en      registered register-file write port (1-cycle latency)
//   issue_valid, issue_rd        issuing FP instruction marks its rd pending
//   chk_rs1..3, chk_rd           hazard query addresses
//   busy_rs1..3, busy_rd         scoreboard bit for each queried register
//   busy_vec                     full scoreboard
//   err_sticky                   WAW issue or unexpected writeback seen since reset
module fp_writeback_arbiter #(
    parameter int N_SRC  = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SRC-1:0]           src_valid,
    output logic [N_SRC-1:0]           src_ready,
    input  logic [N_SRC*ADDR_W-1:0]    src_rd,
    input  logic [N_SRC*DATA_W-1:0]    src_data,
    output logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          wr_data,
    output logic                       wr_en,
    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_rd,
    input  logic [ADDR_W-1:0]          chk_rs1,
    input  logic [ADDR_W-1:0]          chk_rs2,
    input  logic [ADDR_W-1:0]          chk_rs3,
    input  logic [ADDR_W-1:0]          chk_rd,
    output logic                       busy_rs1,
    output logic                       busy_rs2,
    output logic                       busy_rs3,
    output logic                       busy_rd,
    output logic [31:0]                busy_vec,
    output logic                       err_sticky
);

    localparam int              PTR_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [PTR_W:0]  N_SRC_W = (PTR_W+1)'(N_SRC);
    localparam logic [PTR_W-1:0] LAST   = PTR_W'(N_SRC - 1);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [31:0]       busy_q, busy_d;
    logic              err_q, err_d;

    logic              gnt_found;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W:0]    cand;
    logic              xfer;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              clr_hit;

    // Round-robin search: walk ptr, ptr+1, ... wrapping at N_SRC, first valid wins.
    // cand is one bit wider than ptr so the wrap test cannot overflow.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (cand >= N_SRC_W) cand = cand - N_SRC_W;
            if (!gnt_found && src_valid[cand[PTR_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // No grant is visible while reset is asserted, so nothing is consumed then.
    assign xfer = gnt_found && !rst;

    always_comb begin
        src_ready = '0;
        sel_rd    = '0;
        sel_data  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                src_ready[i] = xfer;
                sel_rd       = src_rd[i*ADDR_W +: ADDR_W];
                sel_data     = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A register being written back this cycle frees its scoreboard bit on the
    // same edge, so re-issuing to it now is legal.
    assign clr_hit = wr_en_q && (rd_addr_q == issue_rd);

    always_comb begin
        ptr_d     = ptr_q;
        wr_en_d   = xfer;
        rd_addr_d = rd_addr_q;
        wr_data_d = wr_data_q;
        if (xfer) begin
            ptr_d     = (gnt_idx == LAST) ? '0 : gnt_idx + PTR_W'(1);
            rd_addr_d = sel_rd;
            wr_data_d = sel_data;
        end

        // Clear first, then set: a same-edge set of the same register wins.
        busy_d = busy_q;
        if (wr_en_q)     busy_d[rd_addr_q] = 1'b0;
        if (issue_valid) busy_d[issue_rd]  = 1'b1;

        err_d = err_q
              | (issue_valid && busy_q[issue_rd] && !clr_hit)
              | (wr_en_q && !busy_q[rd_addr_q]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign rd_addr    = rd_addr_q;
    assign wr_data    = wr_data_q;
    assign busy_vec   = busy_q;
    assign err_sticky = err_q;
    assign busy_rs1   = busy_q[chk_rs1];
    assign busy_rs2   = busy_q[chk_rs2];
    assign busy_rs3   = busy_q[chk_rs3];
    assign busy_rd    = busy_q[chk_rd];

endmodule

// File: tb/tb_fp_writeback_arbiter.sv
// Directed bench for fp_writeback_arbiter: a vector table covering the
// basic write path, back-to-back grants and same-edge set/clear, followed by
// hand-written sequences for round-robin fairness, unexpected writeback and
// mid-stream reset.
module tb_fp_writeback_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [14:0] src_rd;
    logic [95:0] src_data;
    logic [4:0]  rd_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_rs1, chk_rs2, chk_rs3, chk_rd;
    logic        busy_rs1, busy_rs2, busy_rs3, busy_rd;
    logic [31:0] busy_vec;
    logic        err_sticky;

    fp_writeback_arbiter #(.N_SRC(3), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_rd(src_rd), .src_data(src_data),
        .rd_addr(rd_addr), .wr_data(wr_data), .wr_en(wr_en),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rs3(chk_rs3), .chk_rd(chk_rd),
        .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .busy_rs3(busy_rs3), .busy_rd(busy_rd),
        .busy_vec(busy_vec), .err_sticky(err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  vld;
        logic [14:0] rd;
        logic [95:0] dat;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  chk;
        logic [2:0]  e_rdy;
        logic        e_wen;
        logic [4:0]  e_addr;
        logic [31:0] e_dat;
        logic [31:0] e_busy;
        logic        e_err;
    } vec_t;

    localparam logic [31:0] DA1 = 32'h40000001;
    localparam logic [31:0] DA2 = 32'h40000002;
    localparam logic [31:0] DA3 = 32'h40000003;
    localparam logic [31:0] ONE = 32'h3F800000;
    localparam logic [31:0] D7A = 32'hC0DE0007;
    localparam logic [31:0] D7B = 32'hC0DE1007;

    vec_t tbl [20];
    int   total = 0;
    int   bad   = 0;

    int          g, prev_g, c0, c2;
    logic [31:0] d0, d2, prev_d;
    logic [31:0] eb;

    function automatic vec_t mk(input logic [2:0] vld, input logic [14:0] rd,
                                input logic [95:0] dat, input logic iv,
                                input logic [4:0] ird, input logic [4:0] chk,
                                input logic [2:0] e_rdy, input logic e_wen,
                                input logic [4:0] e_addr, input logic [31:0] e_dat,
                                input logic [31:0] e_busy, input logic e_err);
        vec_t v;
        v.vld = vld; v.rd = rd; v.dat = dat; v.iv = iv; v.ird = ird; v.chk = chk;
        v.e_rdy = e_rdy; v.e_wen = e_wen; v.e_addr = e_addr; v.e_dat = e_dat;
        v.e_busy = e_busy; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // row: vld rd dat iv ird chk | rdy wen addr dat busy err
        tbl[0]  = mk(3'b000, 15'd0, 96'd0, 1'b1, 5'd1, 5'd3, 3'b000, 1'b0, 5'd0, 32'd0, 32'h0, 1'b0);
        tbl[1]  = mk(3'b000, 15'd0, 96'd0, 1'b1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd0, 32'd0, 32'h2, 1'b0);
        tbl[2]  = mk(3'b000, 15'd0, 96'd0, 1'b1, 5'd3, 5'd3, 3'b000, 1'b0, 5'd0, 32'd0, 32'h6, 1'b0);
        tbl[3]  = mk(3'b111, {5'd3, 5'd2, 5'd1}, {DA3, DA2, DA1}, 1'b0, 5'd0, 5'd3, 3'b001, 1'b0, 5'd0, 32'd0, 32'hE, 1'b0);
        tbl[4]  = mk(3'b110, {5'd3, 5'd2, 5'd1}, {DA3, DA2, DA1}, 1'b0, 5'd0, 5'd3, 3'b010, 1'b1, 5'd1, DA1, 32'hE, 1'b0);
        tbl[5]  = mk(3'b100, {5'd3, 5'd2, 5'd1}, {DA3, DA2, DA1}, 1'b0, 5'd0, 5'd3, 3'b100, 1'b1, 5'd2, DA2, 32'hC, 1'b0);
        tbl[6]  = mk(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd3, 3'b000, 1'b1, 5'd3, DA3, 32'h8, 1'b0);
        tbl[7]  = mk(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd3, 3'b000, 1'b0, 5'd3, DA3, 32'h0, 1'b0);
        tbl[8]  = mk(3'b000, 15'd0, 96'd0, 1'b1, 5'd5, 5'd5, 3'b000, 1'b0, 5'd3, DA3, 32'h0, 1'b0);
        tbl[9]  = mk(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd5, 3'b000, 1'b0, 5'd3, DA3, 32'h20, 1'b0);
        tbl[10] = mk(3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, ONE, 32'd0}, 1'b0, 5'd0, 5'd5, 3'b010, 1'b0, 5'd3, DA3, 32'h20, 1'b0);
        tbl[11] = mk(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd5, 3'b000, 1'b1, 5'd5, ONE, 32'h20, 1'b0);
        tbl[12] = mk(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd5, 3'b000, 1'b0, 5'd5, ONE, 32'h0, 1'b0);
        tbl[13] = mk(3'b000, 15'd0, 96'd0, 1'b1, 5'd7, 5'd7, 3'b000, 1'b0, 5'd5, ONE, 32'h0, 1'b0);
        tbl[14] = mk(3'b001, {5'd0, 5'd0, 5'd7}, {64'd0, D7A}, 1'b0, 5'd0, 5'd7, 3'b001, 1'b0, 5'd5, ONE, 32'h80, 1'b0);
        tbl[15] = mk(3'b000, 15'd0, 96'd0, 1'b1, 5'd7, 5'd7, 3'b000, 1'b1, 5'd7, D7A, 32'h80, 1'b0);
        tbl[16] = mk(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd7, 3'b000, 1'b0, 5'd7, D7A, 32'h80, 1'b0);
        tbl[17] = mk(3'b001, {5'd0, 5'd0, 5'd7}, {64'd0, D7B}, 1'b0, 5'd0, 5'd7, 3'b001, 1'b0, 5'd7, D7A, 32'h80, 1'b0);
        tbl[18] = mk(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd7, 3'b000, 1'b1, 5'd7, D7B, 32'h80, 1'b0);
        tbl[19] = mk(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd7, 3'b000, 1'b0, 5'd7, D7B, 32'h0, 1'b0);

        // Reset for two edges with inputs toggling.
        rst = 1'b1;
        src_valid = 3'b111; src_rd = 15'($urandom); src_data = {$urandom, $urandom, $urandom};
        issue_valid = 1'b1; issue_rd = 5'($urandom);
        chk_rs1 = 5'd1; chk_rs2 = 5'd2; chk_rs3 = 5'd5; chk_rd = 5'd0;
        #2;
        check("rst0 ready", 64'(src_ready), 64'd0);
        next_cycle();
        src_valid = 3'($urandom); src_rd = 15'($urandom); src_data = {$urandom, $urandom, $urandom};
        issue_rd = 5'($urandom);
        @(negedge clk);
        check("rst1 ready", 64'(src_ready), 64'd0);
        check("rst1 wr_en", 64'(wr_en), 64'd0);
        check("rst1 rd_addr", 64'(rd_addr), 64'd0);
        check("rst1 wr_data", 64'(wr_data), 64'd0);
        check("rst1 busy_vec", 64'(busy_vec), 64'd0);
        check("rst1 err", 64'(err_sticky), 64'd0);
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            src_valid = tbl[i].vld; src_rd = tbl[i].rd; src_data = tbl[i].dat;
            issue_valid = tbl[i].iv; issue_rd = tbl[i].ird; chk_rd = tbl[i].chk;
            eb = tbl[i].e_busy;
            @(negedge clk);
            check($sformatf("r%0d ready", i),    64'(src_ready),  64'(tbl[i].e_rdy));
            check($sformatf("r%0d wr_en", i),    64'(wr_en),      64'(tbl[i].e_wen));
            check($sformatf("r%0d rd_addr", i),  64'(rd_addr),    64'(tbl[i].e_addr));
            check($sformatf("r%0d wr_data", i),  64'(wr_data),    64'(tbl[i].e_dat));
            check($sformatf("r%0d busy_vec", i), 64'(busy_vec),   64'(eb));
            check($sformatf("r%0d err", i),      64'(err_sticky), 64'(tbl[i].e_err));
            check($sformatf("r%0d busy_rd", i),  64'(busy_rd),    64'(eb[tbl[i].chk]));
            check($sformatf("r%0d busy_rs1", i), 64'(busy_rs1),   64'(eb[1]));
            check($sformatf("r%0d busy_rs2", i), 64'(busy_rs2),   64'(eb[2]));
            check($sformatf("r%0d busy_rs3", i), 64'(busy_rs3),   64'(eb[5]));
            next_cycle();
        end

        // Fairness: sources 0 (f10) and 2 (f12) always valid; ptr is 1 here,
        // so grants run 2,0,2,0,... Each written register is re-issued in its
        // writeback cycle (legal same-edge set/clear).
        src_valid = 3'b000; issue_valid = 1'b1; issue_rd = 5'd10;
        next_cycle();
        issue_rd = 5'd12;
        next_cycle();
        c0 = 0; c2 = 0; prev_g = 0; prev_d = 32'd0;
        for (int k = 0; k < 8; k++) begin
            g  = (k % 2 == 0) ? 2 : 0;
            d0 = 32'hA0000000 | 32'(c0);
            d2 = 32'hA2000000 | 32'(c2);
            src_valid = 3'b101; src_rd = {5'd12, 5'd0, 5'd10}; src_data = {d2, 32'd0, d0};
            issue_valid = (k > 0); issue_rd = (prev_g == 0) ? 5'd10 : 5'd12;
            @(negedge clk);
            check($sformatf("alt%0d ready", k), 64'(src_ready), 64'(3'b001 << g));
            if (k > 0) begin
                check($sformatf("alt%0d wr_en", k), 64'(wr_en), 64'd1);
                check($sformatf("alt%0d rd_addr", k), 64'(rd_addr), (prev_g == 0) ? 64'd10 : 64'd12);
                check($sformatf("alt%0d wr_data", k), 64'(wr_data), 64'(prev_d));
            end
            check($sformatf("alt%0d err", k), 64'(err_sticky), 64'd0);
            prev_g = g;
            prev_d = (g == 0) ? d0 : d2;
            if (g == 0) c0++; else c2++;
            next_cycle();
        end

        // Unexpected writeback of f9 (never issued); f10 re-issued as it lands.
        src_valid = 3'b001; src_rd = {5'd0, 5'd0, 5'd9}; src_data = {64'd0, 32'h99999999};
        issue_valid = 1'b1; issue_rd = 5'd10;
        @(negedge clk);
        check("x0 ready", 64'(src_ready), 64'b001);
        check("x0 rd_addr", 64'(rd_addr), 64'd10);
        check("x0 wr_data", 64'(wr_data), 64'(prev_d));
        check("x0 err", 64'(err_sticky), 64'd0);
        next_cycle();
        src_valid = 3'b000; issue_valid = 1'b0;
        @(negedge clk);
        check("x1 wr_en", 64'(wr_en), 64'd1);
        check("x1 rd_addr", 64'(rd_addr), 64'd9);
        check("x1 wr_data", 64'(wr_data), 64'h99999999);
        check("x1 err", 64'(err_sticky), 64'd0);
        next_cycle();
        // ptr is 1: source 1 wins, moving ptr to 2 before the reset.
        src_valid = 3'b011; src_rd = {5'd0, 5'd12, 5'd10}; src_data = {32'd0, 32'h11111111, 32'h22222222};
        @(negedge clk);
        check("x2 ready", 64'(src_ready), 64'b010);
        check("x2 wr_en", 64'(wr_en), 64'd0);
        check("x2 err", 64'(err_sticky), 64'd1);
        check("x2 busy_vec", 64'(busy_vec), 64'h1400);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("x3 ready in rst", 64'(src_ready), 64'd0);
        check("x3 wr_en", 64'(wr_en), 64'd1);
        check("x3 rd_addr", 64'(rd_addr), 64'd12);
        check("x3 err", 64'(err_sticky), 64'd1);
        next_cycle();
        rst = 1'b0; src_valid = 3'b110;
        @(negedge clk);
        check("x4 wr_en", 64'(wr_en), 64'd0);
        check("x4 rd_addr", 64'(rd_addr), 64'd0);
        check("x4 wr_data", 64'(wr_data), 64'd0);
        check("x4 busy_vec", 64'(busy_vec), 64'd0);
        check("x4 err", 64'(err_sticky), 64'd0);
        check("x4 ready ptr0", 64'(src_ready), 64'b010);
        next_cycle();
        src_valid = 3'b000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
